// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master: FSM state encoding,
// quarter-phase indices, ACK/NACK bit values and the pad-level decode.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_RSTART = 3'd2,
    ST_BIT    = 3'd3,
    ST_ACK    = 3'd4,
    ST_STOP   = 3'd5,
    ST_HOLD   = 3'd6
  } state_e;

  // Each bus phase is split into four quarters of CLK_DIV clocks.
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef struct packed {
    logic scl;      // SCL level driven by the master
    logic sda_rel;  // 1 = SDA released, 0 = SDA pulled low
  } pad_t;

  // Pad levels for a given phase/quarter. Evaluated on next-state values so
  // the pad flops change on the same edge as the state they belong to.
  function automatic pad_t pad_levels(input state_e st, input logic [1:0] q,
                                      input logic rd, input logic txbit,
                                      input logic nack_out);
    pad_t p;
    p.scl     = 1'b1;
    p.sda_rel = 1'b1;
    case (st)
      ST_START: begin
        p.sda_rel = (q == Q0) || (q == Q1);
      end
      ST_RSTART: begin
        p.scl     = (q != Q0);
        p.sda_rel = (q == Q0) || (q == Q1);
      end
      ST_BIT: begin
        p.scl     = q[1];
        p.sda_rel = rd ? 1'b1 : txbit;
      end
      ST_ACK: begin
        p.scl     = q[1];
        p.sda_rel = rd ? nack_out : 1'b1;
      end
      ST_STOP: begin
        p.scl     = (q != Q0);
        p.sda_rel = q[1];
      end
      ST_HOLD: begin
        p.scl     = 1'b0;
      end
      default: begin
        p.scl     = 1'b1;
        p.sda_rel = 1'b1;
      end
    endcase
    return p;
  endfunction

endpackage

// File: rtl/i2c_master_qtick.sv
// Quarter-period timebase: counts 0..CLK_DIV-1 while run is high and
// pulses tick on the wrap clock. freeze holds the count (clock stretching).
module i2c_master_qtick #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic freeze,
  output logic tick
);

  localparam int W = $clog2(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: cleared when idle, held while frozen, wraps at LAST.
  always_comb begin
    cnt_d = cnt_q;
    if (!run) begin
      cnt_d = '0;
    end else if (!freeze) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = run && !freeze && (cnt_q == LAST);

endmodule

// File: rtl/i2c_master.sv
// Single-master I2C initiator. Executes one byte command at a time:
// optional START / repeated START, 8 data bits MSB first, ACK phase,
// optional STOP. SDA is open-drain through SDA_in_en / SDA_o.
// Optional slave clock stretching is compiled in with I2C_CLK_STRETCH_EN.
//
// Command handshake: a command transfers on a rising clk edge where
// cmd_valid && cmd_ready. cmd_ready is high only in IDLE and HOLD, so a
// held cmd_valid is not taken again until the running command completes
// (rsp_valid). rsp_valid is a one-cycle pulse with no back-pressure.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_start,
  input  logic       cmd_stop,
  input  logic       cmd_read,
  input  logic [7:0] cmd_wdata,
  input  logic       cmd_nack_out,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       busy,
  output logic       SCL_o,
  input  logic       SCL_i,
  input  logic       SDA_i,
  output logic       SDA_in_en,
  output logic       SDA_o,
  output logic [2:0] dbg_state_o
);

  state_e     state_q, state_d;
  logic [1:0] qtr_q, qtr_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic       rd_q, rd_d;
  logic       stop_q, stop_d;
  logic       nko_q, nko_d;
  logic       ackbit_q, ackbit_d;
  logic       busy_q, busy_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic       rsp_nack_q, rsp_nack_d;
  logic       scl_q, scl_d;
  logic       sda_rel_q, sda_rel_d;
  logic       done;
  pad_t       pads_d;

  logic run;
  logic freeze;
  logic tick;

  assign run = (state_q != ST_IDLE) && (state_q != ST_HOLD);

`ifdef I2C_CLK_STRETCH_EN
  // While we release SCL high but the pad still reads low, a slave is
  // stretching the clock: hold the quarter count until SCL really rises.
  assign freeze = scl_q & ~SCL_i;
`else
  logic scl_unused;
  assign scl_unused = SCL_i;
  assign freeze     = 1'b0;
`endif

  i2c_master_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .freeze (freeze),
    .tick   (tick)
  );

  // Next-state, datapath and pad-level decode for the byte sequencer.
  always_comb begin
    state_d     = state_q;
    qtr_d       = qtr_q;
    bit_d       = bit_q;
    sh_d        = sh_q;
    rd_d        = rd_q;
    stop_d      = stop_q;
    nko_d       = nko_q;
    ackbit_d    = ackbit_q;
    busy_d      = busy_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_nack_d  = rsp_nack_q;
    done        = 1'b0;

    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (cmd_valid) begin
          // From IDLE the bus is not ours yet, so a START is always issued.
          if (state_q == ST_IDLE)  state_d = ST_START;
          else if (cmd_start)      state_d = ST_RSTART;
          else                     state_d = ST_BIT;
          qtr_d  = Q0;
          bit_d  = 3'd7;
          sh_d   = cmd_wdata;
          rd_d   = cmd_read;
          stop_d = cmd_stop;
          nko_d  = cmd_nack_out;
          busy_d = 1'b1;
        end
      end
      ST_START, ST_RSTART: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == Q3) state_d = ST_BIT;
        end
      end
      ST_BIT: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if ((qtr_q == Q2) && rd_q) sh_d = {sh_q[6:0], SDA_i};
          if (qtr_q == Q3) begin
            if (!rd_q) sh_d = {sh_q[6:0], 1'b0};
            if (bit_q == 3'd0) state_d = ST_ACK;
            else               bit_d   = bit_q - 3'd1;
          end
        end
      end
      ST_ACK: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if ((qtr_q == Q2) && !rd_q) ackbit_d = SDA_i;
          if (qtr_q == Q3) begin
            if (stop_q) begin
              state_d = ST_STOP;
            end else begin
              state_d = ST_HOLD;
              done    = 1'b1;
            end
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == Q3) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done    = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // A slave NACK is only reported; the command always runs to the end.
    if (done) begin
      rsp_valid_d = 1'b1;
      rsp_nack_d  = rd_q ? nko_q : ackbit_q;
      if (rd_q) rsp_rdata_d = sh_q;
    end

    pads_d    = pad_levels(state_d, qtr_d, rd_d, sh_d[7], nko_d);
    scl_d     = pads_d.scl;
    sda_rel_d = pads_d.sda_rel;
  end

  // State and datapath registers; reset releases both bus lines at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      qtr_q       <= Q0;
      bit_q       <= 3'd7;
      sh_q        <= 8'h00;
      rd_q        <= 1'b0;
      stop_q      <= 1'b0;
      nko_q       <= NACK;
      ackbit_q    <= ACK;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_nack_q  <= 1'b0;
      scl_q       <= 1'b1;
      sda_rel_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      qtr_q       <= qtr_d;
      bit_q       <= bit_d;
      sh_q        <= sh_d;
      rd_q        <= rd_d;
      stop_q      <= stop_d;
      nko_q       <= nko_d;
      ackbit_q    <= ackbit_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_nack_q  <= rsp_nack_d;
      scl_q       <= scl_d;
      sda_rel_q   <= sda_rel_d;
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE) || (state_q == ST_HOLD);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_nack    = rsp_nack_q;
  assign busy        = busy_q;
  assign SCL_o       = scl_q;
  assign SDA_in_en   = sda_rel_q;
  assign SDA_o       = 1'b0;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master (CLK_DIV = 10). A small bus model resolves
// the open-drain SDA line, detects START/STOP, records the bit seen on each
// SCL rise and plays a slave that ACKs writes or returns a byte on reads.
// Latency = clk edges from the accepting edge to the edge launching rsp_valid.
module tb_i2c_master;

  localparam int CLK_DIV = 10;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_BIT  = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic       cmd_start = 1'b0, cmd_stop = 1'b0, cmd_read = 1'b0;
  logic [7:0] cmd_wdata = 8'h00;
  logic       cmd_nack_out = 1'b0;
  logic       rsp_valid, rsp_nack, busy;
  logic [7:0] rsp_rdata;
  logic       SCL_o, SCL_i, SDA_i, SDA_in_en, SDA_o;
  logic [2:0] dbg_state;

  logic       slave_pull = 1'b0;
  logic       stretch = 1'b0;
  logic       sda_bus;
  int         slave_mode = 0;      // 0 silent, 1 ACK writes, 2 send slave_byte
  logic [7:0] slave_byte = 8'h00;

  int n_vec = 0, n_err = 0;
  int cyc = 0, acc_edge = 0, acc_cnt = 0;
  int start_cnt = 0, stop_cnt = 0, k = 0;
  int lat, s0, p0, n_acc;
  logic       mon_q[$];
  logic [8:0] exp_q[$];

  assign sda_bus = (SDA_in_en | SDA_o) & ~slave_pull;
  assign SDA_i   = sda_bus;
  assign SCL_i   = SCL_o & ~stretch;

  i2c_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_read(cmd_read),
    .cmd_wdata(cmd_wdata), .cmd_nack_out(cmd_nack_out),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
    .busy(busy), .SCL_o(SCL_o), .SCL_i(SCL_i), .SDA_i(SDA_i),
    .SDA_in_en(SDA_in_en), .SDA_o(SDA_o), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / cycle bookkeeping ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) begin
      acc_edge <= cyc + 1;
      acc_cnt  <= acc_cnt + 1;
    end
  end

  // ---------------- bus monitor and slave ----------------
  always @(posedge SCL_o) begin
    mon_q.push_back(sda_bus);
    k = k + 1;
  end

  always @(negedge sda_bus) if (SCL_o === 1'b1) begin
    start_cnt = start_cnt + 1;
    k = 0;
    mon_q.delete();
  end

  always @(posedge sda_bus) if (SCL_o === 1'b1) stop_cnt = stop_cnt + 1;

  always @(negedge SCL_o) begin
    if (k >= 9) begin
      k = 0;
      slave_pull = 1'b0;
    end else if (slave_mode == 1) begin
      slave_pull = (k == 8);
    end else if (slave_mode == 2) begin
      slave_pull = (k < 8) ? ~slave_byte[3'(7 - k)] : 1'b0;
    end else begin
      slave_pull = 1'b0;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: first 9 SCL-high bits of the byte against the expected word.
  task automatic check_word(input string tag);
    logic [8:0] w;
    logic [8:0] e;
    w = '0;
    e = exp_q.pop_front();
    check({tag, "_bitcount_ok"}, 32'(mon_q.size() >= 9), 1);
    if (mon_q.size() >= 9) begin
      for (int i = 0; i < 9; i++) w = {w[7:0], mon_q[i]};
      check({tag, "_bus_word"}, 32'(w), 32'(e));
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_cmd(input logic st, input logic sp, input logic rd,
                           input logic [7:0] wd, input logic nko);
    cmd_start    = st;
    cmd_stop     = sp;
    cmd_read     = rd;
    cmd_wdata    = wd;
    cmd_nack_out = nko;
    cmd_valid    = 1'b1;
  endtask

  // Returns on the negedge after the accepting edge.
  task automatic wait_accept(input string tag);
    int i;
    i = 0;
    while (!cmd_ready && i < 1000) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_ready_seen"}, 32'(cmd_ready), 1);
    @(negedge clk);
    check({tag, "_ready_drop"}, 32'(cmd_ready), 0);
  endtask

  task automatic wait_rsp(input string tag, input int max, output int l);
    int i;
    i = 0;
    while (!rsp_valid && i < max) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_rsp_seen"}, 32'(rsp_valid), 1);
    l = rsp_valid ? (cyc - acc_edge) : -1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_scl", 32'(SCL_o), 1);
    check("rst_sda_en", 32'(SDA_in_en), 1);
    check("rst_sda_o", 32'(SDA_o), 0);
    check("rst_ready", 32'(cmd_ready), 1);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rdata", 32'(rsp_rdata), 0);
    check("rst_nack", 32'(rsp_nack), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of a data bit (0x00: SDA held low in bit q1).
    drive_cmd(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    wait_accept("midrst");
    cmd_valid = 1'b0;
    for (int i = 0; i < 100 && dbg_state != S_BIT; i++) @(negedge clk);
    check("midrst_in_bit", 32'(dbg_state), 32'(S_BIT));
    repeat (15) @(negedge clk);
    check("midrst_pre_scl", 32'(SCL_o), 0);
    check("midrst_pre_sda", 32'(SDA_in_en), 0);
    #2 rst = 1'b1;
    #1;
    check("midrst_scl", 32'(SCL_o), 1);
    check("midrst_sda_en", 32'(SDA_in_en), 1);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_ready", 32'(cmd_ready), 1);
    check("midrst_state", 32'(dbg_state), 32'(S_IDLE));
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    slave_pull = 1'b0;
    mon_q.delete();
    @(negedge clk);

    // Write 0xA6 with START, slave ACKs, stay in HOLD.
    slave_mode = 1;
    mon_q.delete();
    s0 = start_cnt;
    exp_q.push_back(9'h14C);
    drive_cmd(1'b1, 1'b0, 1'b0, 8'hA6, 1'b0);
    wait_accept("wr_a6");
    cmd_valid = 1'b0;
    check("wr_a6_busy_during", 32'(busy), 1);
    wait_rsp("wr_a6", 600, lat);
    check("wr_a6_latency", 32'(lat), 400);
    check("wr_a6_nack", 32'(rsp_nack), 0);
    check("wr_a6_busy", 32'(busy), 1);
    check("wr_a6_state", 32'(dbg_state), 32'(S_HOLD));
    check("wr_a6_ready", 32'(cmd_ready), 1);
    check("wr_a6_start_seen", 32'(start_cnt - s0), 1);
    check("wr_a6_hold_scl", 32'(SCL_o), 0);
    check("wr_a6_hold_sda", 32'(SDA_in_en), 1);
    check_word("wr_a6");
    @(negedge clk);
    check("wr_a6_pulse_len", 32'(rsp_valid), 0);

    // Write 0x5A from HOLD with no slave: NACK reported, no abort.
    slave_mode = 0;
    mon_q.delete();
    exp_q.push_back(9'h0B5);
    drive_cmd(1'b0, 1'b0, 1'b0, 8'h5A, 1'b0);
    wait_accept("wr_5a");
    cmd_valid = 1'b0;
    wait_rsp("wr_5a", 500, lat);
    check("wr_5a_latency", 32'(lat), 360);
    check("wr_5a_nack", 32'(rsp_nack), 1);
    check("wr_5a_state", 32'(dbg_state), 32'(S_HOLD));
    check("wr_5a_busy", 32'(busy), 1);
    check_word("wr_5a");

    // Back-to-back writes with cmd_valid held high throughout.
    slave_mode = 1;
    mon_q.delete();
    exp_q.push_back(9'h078);
    exp_q.push_back(9'h102);
    drive_cmd(1'b0, 1'b0, 1'b0, 8'h3C, 1'b0);
    wait_accept("b2b1");
    drive_cmd(1'b0, 1'b0, 1'b0, 8'h81, 1'b0);
    n_acc = acc_cnt;
    wait_rsp("b2b1", 500, lat);
    check("b2b1_latency", 32'(lat), 360);
    check("b2b1_no_early_accept", 32'(acc_cnt), 32'(n_acc));
    check("b2b1_nack", 32'(rsp_nack), 0);
    check_word("b2b1");
    mon_q.delete();
    @(negedge clk);
    cmd_valid = 1'b0;
    check("b2b2_accepted", 32'(acc_cnt), 32'(n_acc + 1));
    check("b2b2_ready_drop", 32'(cmd_ready), 0);
    wait_rsp("b2b2", 500, lat);
    check("b2b2_latency", 32'(lat), 360);
    check_word("b2b2");

    // Read with repeated START, master NACK, STOP; slave returns 0xC3.
    slave_mode = 2;
    slave_byte = 8'hC3;
    mon_q.delete();
    s0 = start_cnt;
    p0 = stop_cnt;
    exp_q.push_back(9'h187);
    drive_cmd(1'b1, 1'b1, 1'b1, 8'h00, 1'b1);
    wait_accept("rd_c3");
    cmd_valid = 1'b0;
    wait_rsp("rd_c3", 700, lat);
    check("rd_c3_latency", 32'(lat), 440);
    check("rd_c3_rdata", 32'(rsp_rdata), 32'h0C3);
    check("rd_c3_nack", 32'(rsp_nack), 1);
    check("rd_c3_rstart_seen", 32'(start_cnt - s0), 1);
    check("rd_c3_stop_seen", 32'(stop_cnt - p0), 1);
    check("rd_c3_busy", 32'(busy), 0);
    check("rd_c3_state", 32'(dbg_state), 32'(S_IDLE));
    check("rd_c3_scl_idle", 32'(SCL_o), 1);
    check("rd_c3_sda_idle", 32'(SDA_in_en), 1);
    check_word("rd_c3");
    slave_mode = 0;
    @(negedge clk);
    check("rd_c3_rdata_held", 32'(rsp_rdata), 32'h0C3);

`ifdef I2C_CLK_STRETCH_EN
    // Clock stretching: 55 clks of SCL held low in bit 3 q2.
    slave_mode = 1;
    mon_q.delete();
    exp_q.push_back(9'h14C);
    drive_cmd(1'b1, 1'b0, 1'b0, 8'hA6, 1'b0);
    wait_accept("st_pre");
    cmd_valid = 1'b0;
    wait_rsp("st_pre", 600, lat);
    check("st_pre_latency", 32'(lat), 400);
    check_word("st_pre");
    mon_q.delete();
    exp_q.push_back(9'h12C);
    drive_cmd(1'b0, 1'b0, 1'b0, 8'h96, 1'b0);
    wait_accept("st");
    cmd_valid = 1'b0;
    begin
      int r;
      logic prev;
      r = 0;
      prev = SCL_o;
      for (int i = 0; i < 1000 && r < 5; i++) begin
        @(negedge clk);
        if (SCL_o && !prev) r++;
        prev = SCL_o;
      end
      check("st_bit3_reached", 32'(r), 5);
    end
    stretch = 1'b1;
    repeat (55) @(negedge clk);
    stretch = 1'b0;
    wait_rsp("st", 600, lat);
    check("st_latency", 32'(lat), 415);
    check("st_nack", 32'(rsp_nack), 0);
    check_word("st");
`endif

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
